// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one Red Pitaya system bus between NM requesters.
// Requests are latched per requester and served one downstream transaction at a time.
module sys_bus_arbiter #(
    parameter int NM  = 2,
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int SW  = DW / 8,
    parameter int TMO = 32
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic [NM*AW-1:0] m_addr_i,
    input  logic [NM*DW-1:0] m_wdata_i,
    input  logic [NM*SW-1:0] m_sel_i,
    input  logic [NM-1:0]    m_wen_i,
    input  logic [NM-1:0]    m_ren_i,
    output logic [DW-1:0]    m_rdata_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [AW-1:0]    s_addr_o,
    output logic [DW-1:0]    s_wdata_o,
    output logic [SW-1:0]    s_sel_o,
    output logic             s_wen_o,
    output logic             s_ren_o,
    input  logic [DW-1:0]    s_rdata_i,
    input  logic             s_err_i,
    input  logic             s_ack_i,
    output logic             busy_o
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic { IDLE, WAIT } state_t;
    state_t state, state_next;

    logic [NM-1:0] pend;
    logic [NM-1:0] strobe;
    logic [NM-1:0] clr;
    logic [AW-1:0] slot_addr  [NM];
    logic [DW-1:0] slot_wdata [NM];
    logic [SW-1:0] slot_sel   [NM];
    logic [NM-1:0] slot_wr;

    logic [IW-1:0] ptr;
    logic [IW-1:0] cur;
    logic [IW-1:0] gnt;
    logic          gnt_valid;
    logic          cur_wr;
    logic [CW-1:0] cnt;
    logic          tmo_hit;
    logic          issue;
    logic          finish;

    generate
        for (genvar gi = 0; gi < NM; gi++) begin : g_req
            assign strobe[gi] = m_wen_i[gi] | m_ren_i[gi];
            assign clr[gi]    = finish && (cur == IW'(gi));
        end
    endgenerate

    // A strobe coinciding with the clear of its own pending bit is kept (set wins).
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            pend    <= '0;
            slot_wr <= '0;
            for (int k = 0; k < NM; k++) begin
                slot_addr[k]  <= '0;
                slot_wdata[k] <= '0;
                slot_sel[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NM; k++) begin
                if (strobe[k] && (!pend[k] || clr[k])) begin
                    pend[k]       <= 1'b1;
                    slot_addr[k]  <= m_addr_i[k*AW +: AW];
                    slot_wdata[k] <= m_wdata_i[k*DW +: DW];
                    slot_sel[k]   <= m_sel_i[k*SW +: SW];
                    slot_wr[k]    <= m_wen_i[k];
                end else if (clr[k]) begin
                    pend[k] <= 1'b0;
                end
            end
        end
    end

    // Search upward from the requester after the last winner, wrapping at NM.
    always_comb begin
        gnt       = ptr;
        gnt_valid = 1'b0;
        for (int i = 1; i <= NM; i++) begin
            if (!gnt_valid && pend[(int'(ptr) + i) % NM]) begin
                gnt_valid = 1'b1;
                gnt       = IW'((int'(ptr) + i) % NM);
            end
        end
    end

    assign tmo_hit = (cnt == CW'(TMO - 1));

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (s_ack_i || tmo_hit) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            ptr       <= IW'(NM - 1);
            cur       <= '0;
            cur_wr    <= 1'b0;
            cnt       <= '0;
            s_addr_o  <= '0;
            s_wdata_o <= '0;
            s_sel_o   <= '0;
            s_wen_o   <= 1'b0;
            s_ren_o   <= 1'b0;
            m_ack_o   <= '0;
            m_err_o   <= '0;
            m_rdata_o <= '0;
        end else begin
            s_wen_o   <= 1'b0;
            s_ren_o   <= 1'b0;
            m_ack_o   <= '0;
            m_err_o   <= '0;
            m_rdata_o <= '0;
            if (issue) begin
                ptr       <= gnt;
                cur       <= gnt;
                cur_wr    <= slot_wr[gnt];
                cnt       <= '0;
                s_addr_o  <= slot_addr[gnt];
                s_wdata_o <= slot_wdata[gnt];
                s_sel_o   <= slot_sel[gnt];
                s_wen_o   <= slot_wr[gnt];
                s_ren_o   <= !slot_wr[gnt];
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            // An ack in the timeout cycle still wins and returns the slave's status.
            if (finish) begin
                m_ack_o[cur] <= 1'b1;
                m_err_o[cur] <= s_ack_i ? s_err_i : 1'b1;
                m_rdata_o    <= (s_ack_i && !cur_wr) ? s_rdata_i : '0;
            end
        end
    end

    assign busy_o = (state == WAIT);

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: timeline-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sys_bus_arbiter;
    localparam int NM  = 2;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NM*AW-1:0] m_addr  = '0;
    logic [NM*DW-1:0] m_wdata = '0;
    logic [NM*SW-1:0] m_sel   = '0;
    logic [NM-1:0]    m_wen   = '0;
    logic [NM-1:0]    m_ren   = '0;
    logic [DW-1:0]    m_rdata;
    logic [NM-1:0]    m_ack;
    logic [NM-1:0]    m_err;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [SW-1:0]    s_sel;
    logic             s_wen;
    logic             s_ren;
    logic [DW-1:0]    s_rdata = '0;
    logic             s_err   = 1'b0;
    logic             s_ack   = 1'b0;
    logic             busy;

    sys_bus_arbiter #(.NM(NM), .DW(DW), .AW(AW), .SW(SW), .TMO(TMO)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_sel_i   (m_sel),
        .m_wen_i   (m_wen),
        .m_ren_i   (m_ren),
        .m_rdata_o (m_rdata),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_sel_o   (s_sel),
        .s_wen_o   (s_wen),
        .s_ren_o   (s_ren),
        .s_rdata_i (s_rdata),
        .s_err_i   (s_err),
        .s_ack_i   (s_ack),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // model: pending requests as seen by the arbiter, and the active transaction timeline
    bit            mp   [NM];
    logic [AW-1:0] ma   [NM];
    logic [DW-1:0] mw   [NM];
    logic [SW-1:0] ms   [NM];
    bit            mwr  [NM];
    int            mptr;
    bit            act;
    int            act_req, act_start, act_resp;
    bit            act_err;
    logic [DW-1:0] act_rdx;

    logic [NM-1:0] e_ack, e_err;
    logic [DW-1:0] e_rdata;
    logic [AW-1:0] e_saddr;
    logic [DW-1:0] e_swdata;
    logic [SW-1:0] e_ssel;
    logic          e_swen, e_sren, e_busy;

    // slave behaviour, optionally forced by directed tests
    int            ack_at;
    bit            ack_e;
    logic [DW-1:0] ack_rd;
    int            fd;
    bit            fe;
    logic [DW-1:0] frd;
    bit            rnd_en, spur_en;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NM; k++) begin
            mp[k] = 1'b0; ma[k] = '0; mw[k] = '0; ms[k] = '0; mwr[k] = 1'b0;
        end
        mptr = NM - 1;
        act = 1'b0; act_req = 0; act_start = 0; act_resp = 0; act_err = 1'b0; act_rdx = '0;
        e_ack = '0; e_err = '0; e_rdata = '0; e_saddr = '0; e_swdata = '0; e_ssel = '0;
        e_swen = 1'b0; e_sren = 1'b0; e_busy = 1'b0;
        ack_at = -1;
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 99);
        if (r < 4) return TMO - 1;
        if (r < 7) return TMO;
        if (r < 9) return TMO + 5;
        return $urandom_range(0, 3);
    endfunction

    // Expected outputs of the cycle just started, from inputs of the previous cycle.
    task automatic model_step();
        bit            idle_prev;
        bit [NM-1:0]   clrv;
        int            g, d;
        if (rst) begin
            model_reset();
            return;
        end
        idle_prev = !act || (cyc - 1 >= act_resp);
        e_ack = '0; e_err = '0; e_rdata = '0; e_swen = 1'b0; e_sren = 1'b0; clrv = '0;
        if (act && cyc == act_resp) begin
            e_ack[act_req] = 1'b1;
            e_err[act_req] = act_err;
            e_rdata        = act_rdx;
            clrv[act_req]  = 1'b1;
        end
        if (idle_prev) begin
            g = -1;
            for (int i = 1; i <= NM; i++)
                if (g < 0 && mp[(mptr + i) % NM]) g = (mptr + i) % NM;
            if (g >= 0) begin
                mptr     = g;
                e_saddr  = ma[g];
                e_swdata = mw[g];
                e_ssel   = ms[g];
                e_swen   = mwr[g];
                e_sren   = !mwr[g];
                d        = (fd >= 0) ? fd : pick_delay();
                ack_e    = (fd >= 0) ? fe : ($urandom_range(0, 3) == 0);
                ack_rd   = (fd >= 0) ? frd : DW'($urandom);
                act       = 1'b1;
                act_req   = g;
                act_start = cyc;
                act_resp  = cyc + 1 + ((d < TMO) ? d : TMO - 1);
                act_err   = (d < TMO) ? ack_e : 1'b1;
                act_rdx   = (d < TMO && !mwr[g]) ? ack_rd : '0;
                ack_at    = (d <= TMO) ? cyc + d : -1;
            end
        end
        e_busy = act && cyc >= act_start && cyc < act_resp;
        for (int k = 0; k < NM; k++) begin
            if ((m_wen[k] | m_ren[k]) && (!mp[k] || clrv[k])) begin
                mp[k]  = 1'b1;
                ma[k]  = m_addr[k*AW +: AW];
                mw[k]  = m_wdata[k*DW +: DW];
                ms[k]  = m_sel[k*SW +: SW];
                mwr[k] = m_wen[k];
            end else if (clrv[k]) begin
                mp[k] = 1'b0;
            end
        end
    endtask

    task automatic slave_drive();
        if (cyc == ack_at) begin
            s_ack = 1'b1; s_err = ack_e; s_rdata = ack_rd;
        end else begin
            s_err   = 1'($urandom_range(0, 1));
            s_rdata = DW'($urandom);
            s_ack   = spur_en && !e_busy && ($urandom_range(0, 19) == 0);
        end
    endtask

    task automatic set_req(input int k, input bit w, input bit r, input logic [AW-1:0] a,
                           input logic [DW-1:0] dta, input logic [SW-1:0] sl);
        m_wen[k] = w;
        m_ren[k] = r;
        m_addr[k*AW +: AW]  = a;
        m_wdata[k*DW +: DW] = dta;
        m_sel[k*SW +: SW]   = sl;
    endtask

    task automatic tick();
        int r;
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        slave_drive();
        m_wen = '0;
        m_ren = '0;
        if (rnd_en && !rst) begin
            for (int k = 0; k < NM; k++) begin
                r = $urandom_range(0, 99);
                if (r < 12)
                    set_req(k, r % 3 != 1, r % 3 != 0, AW'($urandom), DW'($urandom),
                            SW'($urandom_range(0, 15)));
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("s_wen", s_wen, e_swen);
            check("s_ren", s_ren, e_sren);
            check("s_addr", s_addr, e_saddr);
            check("s_wdata", s_wdata, e_swdata);
            check("s_sel", s_sel, e_ssel);
            check("busy", busy, e_busy);
            check("m_ack", m_ack, e_ack);
            check("m_err", m_err, e_err);
            if (e_ack != '0) check("m_rdata", m_rdata, e_rdata);
        end
    end

    initial begin
        fd = -1; fe = 1'b0; frd = '0; rnd_en = 1'b0; spur_en = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_ack", m_ack, 0);
        check("rst_err", m_err, 0);
        check("rst_wen", s_wen, 0);
        check("rst_ren", s_ren, 0);
        check("rst_busy", busy, 0);
        check("rst_saddr", s_addr, 0);
        chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // simultaneous pair from reset: requester 0 then 1
        fd = 0; fe = 1'b0; frd = 32'h1234_5678;
        set_req(0, 1'b1, 1'b0, 32'h4000_0100, 32'h11, 4'hF);
        set_req(1, 1'b0, 1'b1, 32'h4000_0200, 32'h0, 4'hF);
        tick(); tick();
        check("p1_wen0", s_wen, 1);
        check("p1_addr0", s_addr, 32'h4000_0100);
        check("p1_wdata0", s_wdata, 32'h11);
        tick();
        check("p1_ack0", m_ack, 2'b01);
        tick();
        check("p1_ren1", s_ren, 1);
        check("p1_addr1", s_addr, 32'h4000_0200);
        tick();
        check("p1_ack1", m_ack, 2'b10);
        check("p1_rdata1", m_rdata, 32'h1234_5678);
        repeat (3) tick();

        // single read
        fd = 1; frd = 32'hDEAD_BEEF;
        set_req(0, 1'b0, 1'b1, 32'h4000_0010, 32'h0, 4'hF);
        tick();
        check("rd_early", s_ren, 0);
        tick();
        check("rd_ren", s_ren, 1);
        check("rd_addr", s_addr, 32'h4000_0010);
        tick(); tick();
        check("rd_ack", m_ack, 2'b01);
        check("rd_rdata", m_rdata, 32'hDEAD_BEEF);
        check("rd_err", m_err, 2'b00);
        repeat (3) tick();

        // second pair: round-robin now favours requester 1
        fd = 0; frd = 32'h0BAD_F00D;
        set_req(0, 1'b1, 1'b0, 32'h4000_0100, 32'h11, 4'hF);
        set_req(1, 1'b0, 1'b1, 32'h4000_0200, 32'h0, 4'hF);
        tick(); tick();
        check("p2_ren1", s_ren, 1);
        check("p2_addr1", s_addr, 32'h4000_0200);
        tick();
        check("p2_ack1", m_ack, 2'b10);
        tick();
        check("p2_wen0", s_wen, 1);
        check("p2_addr0", s_addr, 32'h4000_0100);
        tick();
        check("p2_ack0", m_ack, 2'b01);
        repeat (3) tick();

        // timeout on a write from requester 1; late ack lands in IDLE
        fd = TMO; fe = 1'b0;
        set_req(1, 1'b1, 1'b0, 32'h4000_0300, 32'hA5, 4'h3);
        tick(); tick();
        check("to_wen", s_wen, 1);
        repeat (31) tick();
        check("to_noack", m_ack, 2'b00);
        check("to_busy", busy, 1);
        tick();
        check("to_ack", m_ack, 2'b10);
        check("to_err", m_err, 2'b10);
        tick();
        check("to_late", m_ack, 2'b00);
        check("to_idle", busy, 0);
        repeat (3) tick();

        // ack in the last waiting cycle beats the timeout
        fd = TMO - 1; fe = 1'b0; frd = 32'hCAFE_F00D;
        set_req(0, 1'b0, 1'b1, 32'h4000_0400, 32'h0, 4'hF);
        repeat (2 + TMO) tick();
        check("co_ack", m_ack, 2'b01);
        check("co_err", m_err, 2'b00);
        check("co_rdata", m_rdata, 32'hCAFE_F00D);
        repeat (3) tick();

        // slave error on a read
        fd = 2; fe = 1'b1; frd = 32'h5555_AAAA;
        set_req(1, 1'b0, 1'b1, 32'h4000_0480, 32'h0, 4'hF);
        repeat (5) tick();
        check("se_ack", m_ack, 2'b10);
        check("se_err", m_err, 2'b10);
        repeat (3) tick();

        // overlapping strobe while pending is dropped
        fd = 1; fe = 1'b0; frd = 32'h0000_0042;
        set_req(0, 1'b0, 1'b1, 32'h4000_0500, 32'h0, 4'hF);
        tick();
        set_req(0, 1'b0, 1'b1, 32'h4000_0600, 32'h0, 4'hF);
        tick();
        check("ov_ren", s_ren, 1);
        check("ov_addr", s_addr, 32'h4000_0500);
        tick(); tick();
        check("ov_ack", m_ack, 2'b01);
        tick(); tick();
        check("ov_single", s_ren, 0);
        check("ov_busy", busy, 0);
        repeat (2) tick();

        // asynchronous reset while waiting
        fd = TMO + 5;
        set_req(0, 1'b0, 1'b1, 32'h4000_0700, 32'h0, 4'hF);
        repeat (5) tick();
        #1 rst = 1'b1;
        model_reset();
        s_ack = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_ren", s_ren, 0);
        check("ar_ack", m_ack, 2'b00);
        check("ar_saddr", s_addr, 0);
        tick(); tick();
        rst = 1'b0;
        fd = 0;
        set_req(0, 1'b1, 1'b0, 32'h4000_0100, 32'h77, 4'hF);
        set_req(1, 1'b0, 1'b1, 32'h4000_0200, 32'h0, 4'hF);
        tick(); tick();
        check("ar_first", s_wen, 1);
        check("ar_addr0", s_addr, 32'h4000_0100);
        repeat (6) tick();

        // randomized traffic
        fd = -1; rnd_en = 1'b1; spur_en = 1'b1;
        repeat (3000) tick();
        rnd_en = 1'b0;
        repeat (2 * TMO + 20) tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
- Shares one downstream Red Pitaya system bus between NM upstream requesters, e.g. several AXI-lite bridges or a debug port.
- Each requester issues single-cycle wen/ren strobes and waits for ack.
- The arbiter latches each request, grants round-robin, and issues one downstream transaction at a time.
- It routes the ack, err and rdata back to the requester, and generates a timeout error when the slave never acks.

Parameters:
- NM, 2, number of requesters (2..8)
- DW, 32, data width
- AW, 32, address width
- SW, DW/8, byte-select width
- TMO, 32, wait cycles before timeout error (>=2)

Ports:
- sys_clk_i  in  1  clock; the only clock
- sys_rst_i  in  1  reset, asynchronous, active-high
- m_addr_i  in  NM*AW  requester addresses, slice k = requester k
- m_wdata_i  in  NM*DW  requester write data
- m_sel_i  in  NM*SW  requester byte selects
- m_wen_i  in  NM  write strobes, one cycle
- m_ren_i  in  NM  read strobes, one cycle
- m_rdata_o  out  DW  read data, shared, valid with m_ack_o
- m_ack_o  out  NM  per-requester ack pulse
- m_err_o  out  NM  per-requester error, valid with m_ack_o
- s_addr_o  out  AW  downstream address
- s_wdata_o  out  DW  downstream write data
- s_sel_o  out  SW  downstream byte select
- s_wen_o  out  1  downstream write strobe
- s_ren_o  out  1  downstream read strobe
- s_rdata_i  in  DW  downstream read data
- s_err_i  in  1  downstream error
- s_ack_i  in  1  downstream ack
- busy_o  out  1  high while a downstream transaction is outstanding

Behaviour:
- Reset: all outputs 0, pending bits 0, state IDLE, round-robin pointer = NM-1, so requester 0 wins first.
- Capture:
  - On m_wen_i[k] | m_ren_i[k], latch addr/wdata/sel and direction into slot k and set pend[k].
  - If wen and ren are both high, it is a write.
  - A strobe while pend[k] is already set is dropped; the latched slot is unchanged.
  - A strobe in the same cycle pend[k] clears is captured (set wins).
- FSM states: IDLE, WAIT.
- IDLE:
  - If any pend bit is set, grant g = first set bit searching upward from ptr+1, modulo NM.
  - Register s_addr/s_wdata/s_sel from slot g.
  - Pulse s_wen_o or s_ren_o high for exactly one cycle.
  - Set ptr = g, clear the timeout counter, go to WAIT.
  - Pend bits are only sampled registered, so a strobe at cycle t gives a downstream strobe at t+2 at the earliest.
- WAIT:
  - s_ack_i is accepted from the cycle s_wen_o/s_ren_o is high onward.
  - On ack, next cycle: m_ack_o[g]=1 for one cycle, m_err_o[g]=s_err_i, m_rdata_o=s_rdata_i (write: 0). Then clear pend[g] and go to IDLE.
  - Counter increments each WAIT cycle. When it reaches TMO without ack: m_ack_o[g]=1, m_err_o[g]=1, m_rdata_o=0, clear pend[g], go to IDLE.
  - If ack and the timeout coincide, the ack wins (err = s_err_i).
- Back-to-back: a new grant can be issued in the cycle after the ack is returned. Minimum spacing between downstream strobes is 2 cycles after the ack.
- s_ack_i seen in IDLE (late ack after a timeout) is ignored.
- s_addr_o/s_wdata_o/s_sel_o hold their value until the next grant.
- m_err_o and m_ack_o are zero for non-granted requesters.
- busy_o = (state == WAIT).
- Asynchronous reset mid-transaction: everything clears immediately, no ack is returned, and the downstream strobe is dropped.
- Fairness: every pending requester is served within NM grants.

Test Plan:
- Single read: m_ren_i[0] with addr 0x40000010, slave acks 1 cycle after s_ren_o with rdata 0xDEADBEEF. Required: s_ren_o 2 cycles after the strobe, then m_ack_o[0] pulse with m_rdata_o=0xDEADBEEF and m_err_o[0]=0.
- Simultaneous requests: req 0 write 0x11 and req 1 read in the same cycle, slave acks immediately. Required: requester 0 is served first, then requester 1. A second simultaneous pair serves 1 then 0 (round-robin).
- Timeout: TMO=32, slave never acks a write from requester 1. Required: m_ack_o[1]=1, m_err_o[1]=1 after 32 WAIT cycles. A late s_ack_i arriving afterwards is ignored and produces no further m_ack_o.
- Slave error: s_ack_i with s_err_i=1 on a read. Required: m_err_o=1 and m_ack_o=1 for that requester only.
- Overlap: requester 0 strobes again while pending. Required: the second strobe is dropped, exactly one downstream transaction occurs, and the original address is used.
- Reset mid-WAIT: assert sys_rst_i during WAIT. Required: all outputs 0 immediately, busy_o=0, and the next request after reset is granted to requester 0.
